// File: rtl/psram_sched_pkg.sv
// Shared definitions for the PSRAM chunk scheduler: FSM state encoding and beat size.
package psram_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2,
        GAP   = 2'd3
    } psram_state_e;

    // One beat on the PSRAM core is 64 bits wide.
    localparam int BEAT_BYTES = 8;

endpackage

// File: rtl/psram_sched_rr_arb.sv
// Round-robin arbiter: the first requester at or after the pointer wins; the grant is one-hot.
module rr_arb #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt
);

    logic w_found;

    // Scan the offsets from the pointer upward; the first pending requester takes the grant.
    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_found && (j == (int'(i_ptr) + k) % NUM_REQ) && i_req[j]) begin
                    o_gnt[j] = 1'b1;
                    w_found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/psram_sched.sv
// PSRAM scheduler: arbitrates requesters and splits each burst into CE-time-limited chunks.
//
//   state | meaning
//   IDLE  | no request owned; arbitrate when enabled
//   ISSUE | chunk command presented to the core
//   XFER  | chunk accepted, waiting for core_done_i
//   GAP   | enforced CE-high time before next chunk or completion
module psram_sched
    import psram_sched_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 24,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic                            en_i,
    input  logic [LEN_WIDTH-1:0]            max_len_i,
    input  logic [3:0]                      gap_i,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic [NUM_REQ-1:0]              req_wr_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len_i,
    output logic [NUM_REQ-1:0]              req_done_o,
    output logic                            core_valid_o,
    input  logic                            core_ready_i,
    output logic                            core_wr_o,
    output logic [ADDR_WIDTH-1:0]           core_addr_o,
    output logic [LEN_WIDTH-1:0]            core_len_o,
    output logic [$clog2(NUM_REQ)-1:0]      core_id_o,
    input  logic                            core_done_i,
    output logic                            busy_o
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [LEN_WIDTH:0] ONE_BEAT = 1;

    psram_state_e           r_state;
    psram_state_e           w_state_nxt;
    logic [ID_W-1:0]        r_ptr;
    logic [ID_W-1:0]        r_id;
    logic                   r_wr;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [LEN_WIDTH-1:0]   r_chunk;
    logic [LEN_WIDTH:0]     r_rem;
    logic [3:0]             r_gap_cnt;
    logic                   r_abort;
    logic [NUM_REQ-1:0]     r_ready;
    logic [NUM_REQ-1:0]     r_done;

    logic [NUM_REQ-1:0]     w_gnt;
    logic [ID_W-1:0]        w_win;
    logic                   w_sel_wr;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic [LEN_WIDTH-1:0]   w_sel_len;
    logic [LEN_WIDTH-1:0]   w_grant_len;
    logic [LEN_WIDTH:0]     w_rem_m1;
    logic [LEN_WIDTH-1:0]   w_reissue_len;
    logic [LEN_WIDTH:0]     w_chunk_beats;
    logic                   w_grant;
    logic                   w_issue;
    logic                   w_reissue;
    logic                   w_finish;

    rr_arb #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (ID_W)
    ) u_rr_arb (
        .i_req (req_valid_i & {NUM_REQ{en_i}}),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt)
    );

    // Turn the one-hot grant into an index and pick that requester's command fields.
    always_comb begin
        w_win      = '0;
        w_sel_wr   = 1'b0;
        w_sel_addr = '0;
        w_sel_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_win      = ID_W'(i);
                w_sel_wr   = req_wr_i[i];
                w_sel_addr = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_len  = req_len_i[i*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

    // Chunk length is the smaller of what is left and the CE-time limit, both in beats-1 form.
    assign w_grant_len   = (w_sel_len > max_len_i) ? max_len_i : w_sel_len;
    assign w_rem_m1      = r_rem - ONE_BEAT;
    assign w_reissue_len = (w_rem_m1 > {1'b0, max_len_i}) ? max_len_i : w_rem_m1[LEN_WIDTH-1:0];
    assign w_chunk_beats = {1'b0, r_chunk} + ONE_BEAT;

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state decode; disable wins over a core handshake so an abandoned chunk is never issued.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_issue     = 1'b0;
        w_reissue   = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_gnt) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!en_i) begin
                    w_state_nxt = IDLE;
                end else if (core_ready_i) begin
                    w_issue     = 1'b1;
                    w_state_nxt = XFER;
                end
            end
            XFER: begin
                if (core_done_i) w_state_nxt = (r_abort || !en_i) ? IDLE : GAP;
            end
            GAP: begin
                if (!en_i) begin
                    w_state_nxt = IDLE;
                end else if (r_gap_cnt == 4'd0) begin
                    if (r_rem != '0) begin
                        w_reissue   = 1'b1;
                        w_state_nxt = ISSUE;
                    end else begin
                        w_finish    = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request context, chunk bookkeeping, gap timer and the one-cycle ready/done pulses.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ptr     <= '0;
            r_id      <= '0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_chunk   <= '0;
            r_rem     <= '0;
            r_gap_cnt <= '0;
            r_abort   <= 1'b0;
            r_ready   <= '0;
            r_done    <= '0;
        end else begin
            r_ready <= '0;
            r_done  <= '0;
            if (w_grant) begin
                r_ready <= w_gnt;
                r_id    <= w_win;
                r_wr    <= w_sel_wr;
                r_addr  <= w_sel_addr;
                r_rem   <= {1'b0, w_sel_len} + ONE_BEAT;
                r_chunk <= w_grant_len;
                r_ptr   <= (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
            end
            if (w_issue) begin
                r_rem  <= r_rem - w_chunk_beats;
                r_addr <= r_addr + ADDR_WIDTH'(w_chunk_beats) * ADDR_WIDTH'(BEAT_BYTES);
            end
            if (r_state == XFER && core_done_i) r_gap_cnt <= gap_i;
            if (r_state == GAP && r_gap_cnt != 4'd0) r_gap_cnt <= r_gap_cnt - 4'd1;
            if (r_state == XFER) begin
                if (!en_i) r_abort <= 1'b1;
            end else begin
                r_abort <= 1'b0;
            end
            if (w_reissue) r_chunk <= w_reissue_len;
            if (w_finish)  r_done[r_id] <= 1'b1;
            if (w_state_nxt == IDLE) r_rem <= '0;
        end
    end

    assign req_ready_o  = r_ready;
    assign req_done_o   = r_done;
    assign core_valid_o = (r_state == ISSUE);
    assign core_wr_o    = r_wr;
    assign core_addr_o  = r_addr;
    assign core_len_o   = r_chunk;
    assign core_id_o    = r_id;
    assign busy_o       = (r_state != IDLE);

endmodule

// File: tb/tb_psram_sched.sv
// Bench for psram_sched: transaction-level reference thread, per-cycle compare, directed and random stimulus.
module tb_psram_sched;

    localparam int NUM_REQ = 2;
    localparam int AW      = 24;
    localparam int LW      = 8;

    typedef struct packed {
        logic          wr;
        logic [0:0]    id;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
    } cmd_t;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic                   en = 1'b0;
    logic [LW-1:0]          max_len = '0;
    logic [3:0]             gap = '0;
    logic [NUM_REQ-1:0]     req_valid = '0;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ-1:0]     req_wr = '0;
    logic [NUM_REQ*AW-1:0]  req_addr = '0;
    logic [NUM_REQ*LW-1:0]  req_len = '0;
    logic [NUM_REQ-1:0]     req_done;
    logic                   core_valid;
    logic                   core_ready = 1'b0;
    logic                   core_wr;
    logic [AW-1:0]          core_addr;
    logic [LW-1:0]          core_len;
    logic [0:0]             core_id;
    logic                   core_done = 1'b0;
    logic                   busy;

    int vectors = 0;
    int miscompares = 0;

    // expected outputs after the most recent rising edge
    bit                 exp_busy = 0;
    bit                 exp_valid = 0;
    bit [NUM_REQ-1:0]   exp_ready = '0;
    bit [NUM_REQ-1:0]   exp_done = '0;
    bit [AW-1:0]        exp_addr = '0;
    bit [LW-1:0]        exp_len = '0;
    bit                 exp_wr = 0;
    bit [0:0]           exp_id = '0;
    int                 m_ptr = 0;

    cmd_t cmd_q[$];
    int   grant_q[$];
    int   done_q[$];
    bit   rand_mode = 0;
    bit   hold_valid = 0;
    int   xfer_cnt = 0;

    psram_sched #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .en_i         (en),
        .max_len_i    (max_len),
        .gap_i        (gap),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_wr_i     (req_wr),
        .req_addr_i   (req_addr),
        .req_len_i    (req_len),
        .req_done_o   (req_done),
        .core_valid_o (core_valid),
        .core_ready_i (core_ready),
        .core_wr_o    (core_wr),
        .core_addr_o  (core_addr),
        .core_len_o   (core_len),
        .core_id_o    (core_id),
        .core_done_i  (core_done),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return 0;
    endfunction

    // Reference: one request at a time, walked as a sequence of chunks, edge by edge.
    task automatic model_run();
        int w, left, clen, addr, g;
        bit stop, abort_x;
        forever begin
            @(posedge clk);
            if (!rst_n) return;
            exp_ready = '0;
            exp_done  = '0;
            if (!(en && (req_valid != '0))) begin
                exp_busy  = 0;
                exp_valid = 0;
                continue;
            end
            w = rr_pick(req_valid, m_ptr);
            m_ptr = (w + 1) % NUM_REQ;
            exp_ready[w] = 1'b1;
            exp_id = 1'(w);
            exp_wr = req_wr[w];
            addr = int'(req_addr[w*AW +: AW]);
            left = int'(req_len[w*LW +: LW]) + 1;
            stop = 0;
            while (!stop) begin
                clen = (left < int'(max_len) + 1) ? left : int'(max_len) + 1;
                exp_busy  = 1;
                exp_valid = 1;
                exp_addr  = addr[AW-1:0];
                exp_len   = LW'(clen - 1);
                forever begin
                    @(posedge clk);
                    if (!rst_n) return;
                    exp_ready = '0;
                    if (!en) begin stop = 1; break; end
                    if (core_ready) break;
                end
                exp_valid = 0;
                if (stop) begin exp_busy = 0; break; end
                left = left - clen;
                addr = (addr + clen * 8) % (1 << AW);
                abort_x = 0;
                forever begin
                    @(posedge clk);
                    if (!rst_n) return;
                    if (!en) abort_x = 1;
                    if (core_done) break;
                end
                if (abort_x) begin exp_busy = 0; break; end
                g = int'(gap);
                for (int k = 0; k <= g; k++) begin
                    @(posedge clk);
                    if (!rst_n) return;
                    if (!en) begin stop = 1; break; end
                end
                if (stop) begin exp_busy = 0; break; end
                if (left == 0) begin
                    exp_done[exp_id] = 1'b1;
                    exp_busy = 0;
                    stop = 1;
                end
            end
        end
    endtask

    initial begin : model
        forever begin
            @(posedge rst_n);
            model_run();
            exp_busy  = 0;
            exp_valid = 0;
            exp_ready = '0;
            exp_done  = '0;
            m_ptr     = 0;
        end
    end

    // Per-cycle compare of DUT outputs against the reference.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_outputs", {busy, core_valid, req_ready, req_done}, 32'd0);
            check("rst_core_fields", {core_wr, core_id, core_len, core_addr[21:0]}, 32'd0);
        end else begin
            check("busy", 32'(busy), 32'(exp_busy));
            check("core_valid", 32'(core_valid), 32'(exp_valid));
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("req_done", 32'(req_done), 32'(exp_done));
            if (exp_valid) begin
                check("core_addr", 32'(core_addr), 32'(exp_addr));
                check("core_len", 32'(core_len), 32'(exp_len));
                check("core_wr", 32'(core_wr), 32'(exp_wr));
                check("core_id", 32'(core_id), 32'(exp_id));
            end
        end
    end

    task automatic next_cycle();
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) grant_q.push_back(i);
            if (req_done[i])  done_q.push_back(i);
        end
        if (rand_mode) begin
            en = ($urandom_range(99) < 97);
            max_len = ($urandom_range(3) == 0) ? '0 : LW'($urandom_range(7));
            if ($urandom_range(15) == 0) max_len = 8'hFF;
            gap = 4'($urandom_range(3));
            core_ready = 1'($urandom_range(1));
            core_done = ($urandom_range(3) == 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(5) == 0) begin
                    req_valid[i] = 1'b1;
                    req_wr[i] = 1'($urandom_range(1));
                    req_addr[i*AW +: AW] = ($urandom_range(3) == 0) ? AW'(24'hFFFFF8 - 8 * $urandom_range(3))
                                                                     : AW'($urandom);
                    req_len[i*LW +: LW] = LW'($urandom_range(12));
                end
            end
        end else begin
            core_ready = 1'b1;
            core_done = 1'b0;
            if (xfer_cnt > 0) begin
                xfer_cnt--;
                if (xfer_cnt == 0) core_done = 1'b1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && !hold_valid) req_valid[i] = 1'b0;
            end
        end
        if (rst_n && core_valid && core_ready && en) begin
            cmd_q.push_back({core_wr, core_id, core_addr, core_len});
            if (!rand_mode) xfer_cnt = 2;
        end
    endtask

    task automatic clear_logs();
        cmd_q.delete();
        grant_q.delete();
        done_q.delete();
    endtask

    task automatic set_req(input int i, input bit wr, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        req_wr[i] = wr;
        req_addr[i*AW +: AW] = addr;
        req_len[i*LW +: LW] = len;
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        for (int n = 0; n < budget && done_q.size() == 0; n++) next_cycle();
    endtask

    task automatic check_cmd(input string name, input int idx, input logic [AW-1:0] addr,
                             input logic [LW-1:0] len, input bit wr, input bit id);
        if (cmd_q.size() > idx) begin
            check({name, "_addr"}, 32'(cmd_q[idx].addr), 32'(addr));
            check({name, "_len"}, 32'(cmd_q[idx].len), 32'(len));
            check({name, "_wr"}, 32'(cmd_q[idx].wr), 32'(wr));
            check({name, "_id"}, 32'(cmd_q[idx].id), 32'(id));
        end
    endtask

    initial begin : stim
        #1 rst_n = 1'b0;
        next_cycle();
        en = 1'b1;
        req_valid = '1;
        next_cycle();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ready", 32'(req_ready), 32'd0);
        check("reset_core_addr", 32'(core_addr), 32'd0);
        req_valid = '0;
        en = 1'b0;
        next_cycle();
        #1 rst_n = 1'b1;

        // single read, fits in one chunk
        clear_logs();
        en = 1'b1; max_len = 8'd7; gap = 4'd0;
        set_req(0, 1'b0, 24'h000100, 8'd3);
        wait_done(40);
        check("t1_chunks", cmd_q.size(), 32'd1);
        check_cmd("t1_c0", 0, 24'h000100, 8'd3, 1'b0, 1'b0);
        check("t1_done_count", done_q.size(), 32'd1);
        if (done_q.size() > 0) check("t1_done_id", done_q[0], 32'd0);
        repeat (3) next_cycle();

        // write split into three chunks
        clear_logs();
        max_len = 8'd3;
        set_req(1, 1'b1, 24'h000000, 8'd9);
        wait_done(80);
        repeat (6) next_cycle();
        check("t2_chunks", cmd_q.size(), 32'd3);
        check_cmd("t2_c0", 0, 24'h000000, 8'd3, 1'b1, 1'b1);
        check_cmd("t2_c1", 1, 24'h000020, 8'd3, 1'b1, 1'b1);
        check_cmd("t2_c2", 2, 24'h000040, 8'd1, 1'b1, 1'b1);
        check("t2_done_count", done_q.size(), 32'd1);
        if (done_q.size() > 0) check("t2_done_id", done_q[0], 32'd1);

        // round-robin from reset with both requesters held
        #1 rst_n = 1'b0;
        next_cycle();
        #1 rst_n = 1'b1;
        clear_logs();
        max_len = 8'd7;
        hold_valid = 1;
        set_req(0, 1'b0, 24'h000010, 8'd0);
        set_req(1, 1'b0, 24'h000020, 8'd0);
        for (int n = 0; n < 60 && grant_q.size() < 3; n++) next_cycle();
        check("t3_grants", grant_q.size(), 32'd3);
        if (grant_q.size() >= 3) begin
            check("t3_g0", grant_q[0], 32'd0);
            check("t3_g1", grant_q[1], 32'd1);
            check("t3_g2", grant_q[2], 32'd0);
        end
        req_valid = '0;
        hold_valid = 0;
        repeat (20) next_cycle();

        // address wrap with single-beat chunks
        clear_logs();
        max_len = 8'd0;
        set_req(0, 1'b0, 24'hFFFFF8, 8'd1);
        wait_done(40);
        check("t4_chunks", cmd_q.size(), 32'd2);
        check_cmd("t4_c0", 0, 24'hFFFFF8, 8'd0, 1'b0, 1'b0);
        check_cmd("t4_c1", 1, 24'h000000, 8'd0, 1'b0, 1'b0);
        repeat (3) next_cycle();

        // disable during the first of three chunks
        clear_logs();
        max_len = 8'd3;
        set_req(0, 1'b1, 24'h001000, 8'd11);
        for (int n = 0; n < 20 && cmd_q.size() == 0; n++) next_cycle();
        next_cycle();
        en = 1'b0;
        repeat (8) next_cycle();
        check("t5_busy_after_abort", 32'(busy), 32'd0);
        check("t5_chunks", cmd_q.size(), 32'd1);
        check("t5_no_done", done_q.size(), 32'd0);
        en = 1'b1;
        repeat (5) next_cycle();
        check("t5_stays_idle", 32'(busy), 32'd0);

        // reset in the middle of a transfer
        clear_logs();
        set_req(0, 1'b0, 24'h002000, 8'd5);
        for (int n = 0; n < 20 && cmd_q.size() == 0; n++) next_cycle();
        next_cycle();
        #1 rst_n = 1'b0;
        next_cycle();
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_pulses", 32'({req_ready, req_done}), 32'd0);
        check("t6_rst_len", 32'(core_len), 32'd0);
        xfer_cnt = 0;
        next_cycle();
        #1 rst_n = 1'b1;
        repeat (5) next_cycle();
        check("t6_no_done", done_q.size(), 32'd0);

        // randomized traffic against the reference
        clear_logs();
        rand_mode = 1;
        repeat (2000) next_cycle();
        #1 rst_n = 1'b0;
        next_cycle();
        next_cycle();
        #1 rst_n = 1'b1;
        repeat (2000) next_cycle();
        check("rand_progress", 32'(grant_q.size() > 20), 32'd1);
        check("rand_completions", 32'(done_q.size() > 10), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
